// File: rtl/wb_stage.sv
// Writeback stage: merges execute results and load responses into one registered
// register-file write per cycle, with a one-entry hold for displaced execute results.
module wb_stage #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ex_valid_i,
  output logic                    ex_ready_o,
  input  logic                    ex_we_i,
  input  logic [4:0]              ex_rd_i,
  input  logic [DATA_WIDTH-1:0]   ex_wdata_i,
  input  logic                    lsu_valid_i,
  input  logic [4:0]              lsu_rd_i,
  input  logic [DATA_WIDTH-1:0]   lsu_rdata_i,
  input  logic [2:0]              lsu_funct3_i,
  input  logic [1:0]              lsu_addr_lo_i,
  output logic                    rf_wen_o,
  output logic [4:0]              rf_rd_o,
  output logic [DATA_WIDTH-1:0]   rf_wdata_o,
  output logic [DATA_WIDTH/8-1:0] rf_wstrb_o,
  output logic                    load_err_o,
  output logic [31:0]             retired_o
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;

  // Output register (drives the write port and the forwarding path)
  logic                  r_out_valid;
  logic                  r_out_we;
  logic                  r_out_err;
  logic [4:0]            r_out_rd;
  logic [DATA_WIDTH-1:0] r_out_data;

  // Hold register for an execute result displaced by a load
  logic                  r_hold_valid;
  logic                  r_hold_we;
  logic [4:0]            r_hold_rd;
  logic [DATA_WIDTH-1:0] r_hold_data;

  logic [31:0]           r_retired;

  logic                  w_ex_hs;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic                  w_load_err;

  logic                  w_out_valid;
  logic                  w_out_we;
  logic                  w_out_err;
  logic [4:0]            w_out_rd;
  logic [DATA_WIDTH-1:0] w_out_data;
  logic                  w_hold_valid;
  logic                  w_hold_we;
  logic [4:0]            w_hold_rd;
  logic [DATA_WIDTH-1:0] w_hold_data;

  // Ready depends only on hold occupancy and reset, so upstream never sees a comb loop
  assign ex_ready_o = ~r_hold_valid & ~rst;
  assign w_ex_hs    = ex_valid_i & ex_ready_o;

  assign w_shifted  = lsu_rdata_i >> {lsu_addr_lo_i, 3'b000};

  // Load alignment check and sign/zero extension
  always_comb begin
    w_load_data = '0;
    w_load_err  = 1'b0;
    unique case (lsu_funct3_i)
      3'b000: w_load_data = {{(DATA_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
      3'b001: begin
        w_load_data = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
        w_load_err  = lsu_addr_lo_i[0];
      end
      3'b010: begin
        w_load_data = w_shifted;
        w_load_err  = (lsu_addr_lo_i != 2'b00);
      end
      3'b100: w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_shifted[7:0]};
      3'b101: begin
        w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]};
        w_load_err  = lsu_addr_lo_i[0];
      end
      default: w_load_err = 1'b1;
    endcase
  end

  // Source selection: load, then held entry, then execute handshake, else bubble
  always_comb begin
    w_out_valid  = 1'b0;
    w_out_we     = 1'b0;
    w_out_err    = 1'b0;
    w_out_rd     = '0;
    w_out_data   = '0;
    w_hold_valid = r_hold_valid;
    w_hold_we    = r_hold_we;
    w_hold_rd    = r_hold_rd;
    w_hold_data  = r_hold_data;
    if (lsu_valid_i) begin
      // A faulting load still consumes the slot, just without a write
      w_out_valid = 1'b1;
      w_out_we    = ~w_load_err;
      w_out_err   = w_load_err;
      w_out_rd    = lsu_rd_i;
      w_out_data  = w_load_err ? '0 : w_load_data;
      if (w_ex_hs) begin
        w_hold_valid = 1'b1;
        w_hold_we    = ex_we_i;
        w_hold_rd    = ex_rd_i;
        w_hold_data  = ex_wdata_i;
      end
    end else if (r_hold_valid) begin
      w_out_valid  = 1'b1;
      w_out_we     = r_hold_we;
      w_out_rd     = r_hold_rd;
      w_out_data   = r_hold_data;
      w_hold_valid = 1'b0;
    end else if (w_ex_hs) begin
      w_out_valid = 1'b1;
      w_out_we    = ex_we_i;
      w_out_rd    = ex_rd_i;
      w_out_data  = ex_wdata_i;
    end
  end

  // Output and hold registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_we     <= 1'b0;
      r_out_err    <= 1'b0;
      r_out_rd     <= '0;
      r_out_data   <= '0;
      r_hold_valid <= 1'b0;
      r_hold_we    <= 1'b0;
      r_hold_rd    <= '0;
      r_hold_data  <= '0;
    end else begin
      r_out_valid  <= w_out_valid;
      r_out_we     <= w_out_we;
      r_out_err    <= w_out_err;
      r_out_rd     <= w_out_rd;
      r_out_data   <= w_out_data;
      r_hold_valid <= w_hold_valid;
      r_hold_we    <= w_hold_we;
      r_hold_rd    <= w_hold_rd;
      r_hold_data  <= w_hold_data;
    end
  end

  // Count writes as the register file commits them (wraps naturally)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired <= '0;
    end else if (rf_wen_o) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  // x0 writes are dropped here but still occupy their slot
  assign rf_wen_o   = r_out_valid & r_out_we & (r_out_rd != 5'd0);
  assign rf_rd_o    = r_out_rd;
  assign rf_wdata_o = r_out_data;
  assign rf_wstrb_o = {StrbW{rf_wen_o}};
  assign load_err_o = r_out_valid & r_out_err;
  assign retired_o  = r_retired;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus random traffic against a
// queue-based reference model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic        ex_we_i;
  logic [4:0]  ex_rd_i;
  logic [31:0] ex_wdata_i;
  logic        lsu_valid_i;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_rdata_i;
  logic [2:0]  lsu_funct3_i;
  logic [1:0]  lsu_addr_lo_i;
  logic        rf_wen_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_wdata_o;
  logic [3:0]  rf_wstrb_o;
  logic        load_err_o;
  logic [31:0] retired_o;

  wb_stage #(.DATA_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid_i    (ex_valid_i),
    .ex_ready_o    (ex_ready_o),
    .ex_we_i       (ex_we_i),
    .ex_rd_i       (ex_rd_i),
    .ex_wdata_i    (ex_wdata_i),
    .lsu_valid_i   (lsu_valid_i),
    .lsu_rd_i      (lsu_rd_i),
    .lsu_rdata_i   (lsu_rdata_i),
    .lsu_funct3_i  (lsu_funct3_i),
    .lsu_addr_lo_i (lsu_addr_lo_i),
    .rf_wen_o      (rf_wen_o),
    .rf_rd_o       (rf_rd_o),
    .rf_wdata_o    (rf_wdata_o),
    .rf_wstrb_o    (rf_wstrb_o),
    .load_err_o    (load_err_o),
    .retired_o     (retired_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    bit [4:0]    rd;
    bit [31:0]   data;
  } entry_t;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference model: what the write port shows now, pending EX entries, commit count
  entry_t      hold_q[$];
  bit          e_valid;
  bit          e_we;
  bit          e_err;
  bit [4:0]    e_rd;
  bit [31:0]   e_data;
  bit [31:0]   e_retired;

  function automatic bit exp_wen();
    return e_valid && e_we && (e_rd != 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Load semantics from the architectural definition, using plain arithmetic
  function automatic void load_model(input bit [31:0] raw, input bit [2:0] f3,
                                     input bit [1:0] off, output bit [31:0] val,
                                     output bit err);
    longint unsigned w;
    longint unsigned b;
    longint unsigned h;
    w   = longint'(raw) / (longint'(1) << (8 * int'(off)));
    b   = w % 256;
    h   = w % 65536;
    val = 0;
    err = 0;
    case (f3)
      3'd0: val = (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
      3'd1: begin err = (off % 2) != 0; val = (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h); end
      3'd2: begin err = off != 0; val = raw; end
      3'd4: val = 32'(b);
      3'd5: begin err = (off % 2) != 0; val = 32'(h); end
      default: err = 1;
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".wen"}, {31'd0, rf_wen_o}, {31'd0, exp_wen()});
    chk({tag, ".wstrb"}, {28'd0, rf_wstrb_o}, exp_wen() ? 32'hF : 32'h0);
    chk({tag, ".err"}, {31'd0, load_err_o}, {31'd0, e_valid && e_err});
    chk({tag, ".retired"}, retired_o, e_retired);
    if (exp_wen()) begin
      chk({tag, ".rd"}, {27'd0, rf_rd_o}, {27'd0, e_rd});
      chk({tag, ".data"}, rf_wdata_o, e_data);
    end
  endtask

  // One clock cycle: called just after a falling edge, returns just after the next one
  task automatic step(input string tag, input bit exv, input bit exwe, input bit [4:0] exrd,
                      input bit [31:0] exwd, input bit lv, input bit [4:0] lrd,
                      input bit [31:0] lrdata, input bit [2:0] lf3, input bit [1:0] loff);
    bit      hs;
    bit      lerr;
    bit [31:0] lval;
    entry_t  ex_e;
    entry_t  h;
    ex_valid_i    = exv;
    ex_we_i       = exwe;
    ex_rd_i       = exrd;
    ex_wdata_i    = exwd;
    lsu_valid_i   = lv;
    lsu_rd_i      = lrd;
    lsu_rdata_i   = lrdata;
    lsu_funct3_i  = lf3;
    lsu_addr_lo_i = loff;
    #1;
    chk({tag, ".ready"}, {31'd0, ex_ready_o}, {31'd0, hold_q.size() == 0});
    hs = exv && (hold_q.size() == 0);
    ex_e.we = exwe; ex_e.rd = exrd; ex_e.data = exwd;
    if (exp_wen()) e_retired++;
    e_err = 0;
    if (lv) begin
      load_model(lrdata, lf3, loff, lval, lerr);
      e_valid = 1; e_we = !lerr; e_err = lerr; e_rd = lrd; e_data = lval;
      if (hs) hold_q.push_back(ex_e);
    end else if (hold_q.size() > 0) begin
      h = hold_q.pop_front();
      e_valid = 1; e_we = h.we; e_rd = h.rd; e_data = h.data;
    end else if (hs) begin
      e_valid = 1; e_we = exwe; e_rd = exrd; e_data = exwd;
    end else begin
      e_valid = 0; e_we = 0;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ex(input string tag, input bit [4:0] rd, input bit [31:0] d);
    step(tag, 1, 1, rd, d, 0, 0, 0, 0, 0);
  endtask

  task automatic ld(input string tag, input bit [4:0] rd, input bit [31:0] raw,
                    input bit [2:0] f3, input bit [1:0] off);
    step(tag, 0, 0, 0, 0, 1, rd, raw, f3, off);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".wen"}, {31'd0, rf_wen_o}, 32'd0);
    chk({tag, ".rd"}, {27'd0, rf_rd_o}, 32'd0);
    chk({tag, ".wdata"}, rf_wdata_o, 32'd0);
    chk({tag, ".wstrb"}, {28'd0, rf_wstrb_o}, 32'd0);
    chk({tag, ".err"}, {31'd0, load_err_o}, 32'd0);
    chk({tag, ".ready"}, {31'd0, ex_ready_o}, 32'd0);
    chk({tag, ".retired"}, retired_o, 32'd0);
  endtask

  task automatic model_clear();
    hold_q.delete();
    e_valid = 0; e_we = 0; e_err = 0; e_rd = 0; e_data = 0; e_retired = 0;
  endtask

  // Hold reset for a few cycles with all inputs toggling, then release at a falling edge
  task automatic reset_phase(input string tag);
    rst = 1'b1;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      ex_valid_i    = 1'($urandom);
      ex_we_i       = 1'($urandom);
      ex_rd_i       = 5'($urandom);
      ex_wdata_i    = $urandom;
      lsu_valid_i   = 1'($urandom);
      lsu_rd_i      = 5'($urandom);
      lsu_rdata_i   = $urandom;
      lsu_funct3_i  = 3'($urandom);
      lsu_addr_lo_i = 2'($urandom);
      #1;
      check_all_zero(tag);
      @(posedge clk);
      #1;
      check_all_zero(tag);
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ex_valid_i = 0; ex_we_i = 0; ex_rd_i = 0; ex_wdata_i = 0;
    lsu_valid_i = 0; lsu_rd_i = 0; lsu_rdata_i = 0; lsu_funct3_i = 0; lsu_addr_lo_i = 0;
    model_clear();
    @(negedge clk);
    reset_phase("reset");

    // First cycle after release can accept
    ex("ex1", 5'd1, 32'h11);
    ex("ex2", 5'd2, 32'h22);
    ex("ex3", 5'd3, 32'h33);
    idle("ex_drain");
    chk("ex_stream.retired", retired_o, 32'd3);

    // Collision: load wins, execute entry written one cycle later
    step("coll", 1, 1, 5'd5, 32'hAAAA, 1, 5'd6, 32'h12345678, 3'b010, 2'd0);
    chk("coll.first_rd", {27'd0, rf_rd_o}, 32'd6);
    idle("coll_drain");
    chk("coll.second_rd", {27'd0, rf_rd_o}, 32'd5);
    idle("coll_after");

    // Load extension
    ld("lb3", 5'd7, 32'h80F17F01, 3'b000, 2'd3);
    chk("lb3.val", rf_wdata_o, 32'hFFFFFF80);
    ld("lbu2", 5'd8, 32'h80F17F01, 3'b100, 2'd2);
    chk("lbu2.val", rf_wdata_o, 32'h000000F1);
    ld("lh2", 5'd9, 32'h80F17F01, 3'b001, 2'd2);
    chk("lh2.val", rf_wdata_o, 32'hFFFF80F1);
    ld("lhu0", 5'd10, 32'h80F17F01, 3'b101, 2'd0);
    chk("lhu0.val", rf_wdata_o, 32'h00007F01);

    // Errors and x0
    ld("lh_mis", 5'd11, 32'h1234, 3'b001, 2'd1);
    chk("lh_mis.err", {31'd0, load_err_o}, 32'd1);
    ld("ill011", 5'd12, 32'h1234, 3'b011, 2'd0);
    chk("ill011.err", {31'd0, load_err_o}, 32'd1);
    ex("x0", 5'd0, 32'hDEAD);
    chk("x0.wen", {31'd0, rf_wen_o}, 32'd0);
    // Faulting load displacing a held entry: the entry still waits
    step("err_coll", 1, 1, 5'd13, 32'h1313, 1, 5'd14, 32'h0, 3'b110, 2'd0);
    step("err_hold", 0, 0, 0, 0, 1, 5'd15, 32'hCAFE0000, 3'b101, 2'd2);
    idle("err_drain");
    idle("err_after");

    // Counter wrap
    force dut.r_retired = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired;
    e_retired = 32'hFFFF_FFFF;
    ex("wrap_w", 5'd4, 32'h44);
    idle("wrap");
    chk("wrap.zero", retired_o, 32'd0);

    // Asynchronous reset while an entry is held
    step("rst_coll", 1, 1, 5'd20, 32'h2020, 1, 5'd21, 32'h21, 3'b010, 2'd0);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    reset_phase("rst_mid_hold");
    for (int i = 0; i < 3; i++) idle("rst_no_write");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 99) < 60), 1'($urandom), 5'($urandom), $urandom,
           ($urandom_range(0, 99) < 35), 5'($urandom), $urandom, 3'($urandom), 2'($urandom));
    end
    for (int i = 0; i < 3; i++) idle("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the core, sitting directly upstream of the register file's single write port. It merges results from the execute stage (valid/ready handshake) and the load-store unit (no backpressure) into one registered write per cycle. It aligns and sign- or zero-extends load data and buffers one displaced execute result. Its registered outputs drive the register-file write port and double as the forwarding source for earlier stages.

## Interface
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous and active-high.
- ex_valid_i  in  1  execute result valid.
- ex_ready_o  out  1  stage can accept an execute result this cycle.
- ex_we_i  in  1  instruction writes rd.
- ex_rd_i  in  5  destination register.
- ex_wdata_i  in  DATA_WIDTH  execute result.
- lsu_valid_i  in  1  load response valid; always accepted.
- lsu_rd_i  in  5  load destination register.
- lsu_rdata_i  in  DATA_WIDTH  raw aligned memory word.
- lsu_funct3_i  in  3  load type.
- lsu_addr_lo_i  in  2  byte offset of the load address.
- rf_wen_o  out  1  register-file write enable.
- rf_rd_o  out  5  write address.
- rf_wdata_o  out  DATA_WIDTH  write data.
- rf_wstrb_o  out  DATA_WIDTH/8  byte strobes; all ones whenever rf_wen_o=1, otherwise zero.
- load_err_o  out  1  one-cycle pulse: a load was dropped as misaligned or illegal.
- retired_o  out  32  count of committed register writes.

## Operation
- State:
  - Output register: valid, we, rd, data.
  - Hold register: one entry, hold_valid.
  - retired_o counter.
- ex_ready_o = !hold_valid && !rst.
- Source selection per cycle, in priority order:
  1. lsu_valid_i: the load goes to the output register.
  2. hold_valid: the held entry goes to the output register and the hold empties.
  3. EX handshake (ex_valid_i && ex_ready_o): the EX entry goes to the output register.
  4. Otherwise: bubble (output valid=0).
- If the LSU wins while an EX handshake also occurs, the EX entry is captured into the hold register.
- An EX handshake never occurs while hold_valid=1, so no EX entry is ever lost.
- rf_wen_o = out_valid && out_we && (rf_rd_o != 0). Writes to x0 are suppressed but still consume the slot.
- Load extension, applied to data shifted right by 8*lsu_addr_lo_i:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: whole word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
- Load errors (misaligned: LH/LHU with addr_lo[0]=1, or LW with addr_lo≠0; illegal: funct3 011, 110 or 111):
  - The slot is still taken with we=0.
  - load_err_o is high in the same cycle the slot appears on the outputs.
  - A held EX entry still waits.
- retired_o increments by 1 on each rising edge where rf_wen_o=1; it wraps from 0xFFFFFFFF to 0.

## Timing
- Latency: an entry selected before edge N appears on the rf_* outputs from edge N until edge N+1. The register file commits it at edge N+1.
- A held EX entry adds exactly one cycle per displacing load.
- ex_ready_o is combinational from hold_valid and rst only. It never depends on ex_valid_i or lsu_valid_i.
- Back-to-back loads with an entry held: the hold persists and ex_ready_o stays 0 until the first cycle with lsu_valid_i=0. The held entry then drains, and ex_ready_o returns to 1 the following cycle.
- While rst is asserted, every output is 0:
  - rf_wen_o, rf_rd_o, rf_wdata_o, rf_wstrb_o, load_err_o, ex_ready_o.
  - retired_o=0.
  - hold_valid=0.
- Reset mid-operation discards the hold and output registers immediately (asynchronous). No write is issued after rst rises.
- First acceptance is possible in the first cycle after rst deasserts.

## Test plan
- Reset: rst=1 with all inputs toggling -> every output 0. After release, ex_ready_o=1 and retired_o=0.
- EX stream: 3 back-to-back EX results (x1=0x11, x2=0x22, x3=0x33) -> rf_wen_o high for 3 consecutive cycles, one cycle after each handshake, in order. retired_o=3.
- Collision: EX x5=0xAAAA and LSU LW x6=0x12345678 in the same cycle -> x6 is written first and x5 the next cycle. ex_ready_o=0 for exactly one cycle.
- Load extension: rdata=0x80F17F01 -> LB offset 3 gives 0xFFFFFF80; LBU offset 2 gives 0x000000F1; LH offset 2 gives 0xFFFF80F1; LHU offset 0 gives 0x00007F01.
- Errors: LH with offset 1, and funct3=011 -> load_err_o pulses for each, rf_wen_o=0, retired_o unchanged. EX write with rd=0 -> rf_wen_o=0.
- Wrap and reset: preload retired_o to 0xFFFFFFFF, then commit one write -> retired_o=0. Assert rst while an entry is held -> no write of that entry ever appears.
